store_rmw_unit: RTL and testbench

STORE_RMW_UNIT -- requirements
Module: store_rmw_unit

---
 rtl/store_rmw_unit.sv | 129 ++++++++++++
 tb/tb_store_rmw_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_unit.sv
// Store read-modify-write unit.
// Takes one word store with a per-bit (byte-granular) write mask and turns it
// into memory traffic. An empty mask completes with no access. A full mask is
// a single write. A partial mask reads the word, merges it, then writes it back.
// All memory-side outputs come straight from flops and hold until mem_ack.
module store_rmw_unit #(
   parameter int ADDR_W = 30
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [31:0]       req_mask,
   output logic              done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [31:0]       mask_q, mask_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       merged;

   // Old word with the store's bytes overlaid; data_q is already masked.
   assign merged = (mem_rdata & ~mask_q) | data_q;

   // Next-state and next memory-command decode.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      mask_d      = mask_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d     = req_addr;
               // Masked-out bits may be undefined; clear them on the way in.
               data_d     = req_data & req_mask;
               mask_d     = req_mask;
               mem_addr_d = req_addr;
               if (req_mask == 32'h0) begin
                  state_d = DONE;
               end else if (&req_mask) begin
                  state_d     = WRITE;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_wdata_d = req_data & req_mask;
               end else begin
                  state_d     = READ;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_wdata_d = 32'h0;
               end
            end
         end
         READ: begin
            if (mem_ack) begin
               state_d     = WRITE;
               mem_we_d    = 1'b1;
               mem_wdata_d = merged;
            end
         end
         WRITE: begin
            if (mem_ack) begin
               state_d     = DONE;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_wdata_d = 32'h0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   // State and command registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         data_q      <= 32'h0;
         mask_q      <= 32'h0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         mask_q      <= mask_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign done      = (state_q == DONE);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Scoreboard bench for store_rmw_unit: stimulus pushes expected memory
// accesses and done pulses; a negedge monitor pops and compares them.
module tb_store_rmw_unit;

   localparam int ADDR_W = 30;
   localparam int K_READ = 0, K_WRITE = 1, K_DONE = 2;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      int          lat;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_data;
   logic [31:0]       req_mask;
   logic              done;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   last_done = -100;
   int   ack_delay = 0;
   logic [31:0] rdata_val = 32'h0;
   exp_t exp_q[$];

   store_rmw_unit #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
      .done(done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data, input int lat);
      exp_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.lat = lat;
      exp_q.push_back(e);
   endtask

   // Memory model: acks after ack_delay waiting cycles, counter restarts per access.
   initial begin
      int  wait_cnt;
      bit  completed;
      wait_cnt = 0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         completed = mem_req && mem_ack;
         @(posedge clk);
         #1;
         mem_rdata = rdata_val;
         if (!mem_req) begin
            wait_cnt = 0;
            mem_ack = 1'b0;
         end else begin
            if (completed) wait_cnt = 0;
            mem_ack = (wait_cnt >= ack_delay);
            wait_cnt++;
         end
      end
   end

   // Monitor: compares every completed access and done pulse against the queue.
   initial begin
      bit          in_wait;
      logic [31:0] p_addr, p_wdata;
      logic        p_we;
      exp_t        e;
      in_wait = 0;
      p_addr = 0; p_wdata = 0; p_we = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            in_wait = 0;
         end else begin
            if (req_valid && req_ready) acc_cyc = cyc;
            if (mem_req) check("ready_low_while_busy", {31'h0, req_ready}, 32'h0);
            if (mem_req && !mem_ack) begin
               if (in_wait) begin
                  check("stable_addr", {2'b0, mem_addr}, p_addr);
                  check("stable_we", {31'h0, mem_we}, {31'h0, p_we});
                  check("stable_wdata", mem_wdata, p_wdata);
               end
               in_wait = 1;
               p_addr = {2'b0, mem_addr}; p_we = mem_we; p_wdata = mem_wdata;
            end else begin
               in_wait = 0;
            end
            if (mem_req && mem_ack) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_access", {2'b0, mem_addr}, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("access_kind", {31'h0, mem_we}, (e.kind == K_WRITE) ? 32'h1 : 32'h0);
                  check("access_addr", {2'b0, mem_addr}, e.addr);
                  if (e.kind == K_WRITE) check("write_data", mem_wdata, e.data);
                  $display("access we=%0d addr=%h wdata=%h at cycle %0d", mem_we, mem_addr, mem_wdata, cyc);
               end
            end
            if (done) begin
               last_done = cyc;
               check("done_no_mem_req", {31'h0, mem_req}, 32'h0);
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 32'h1, 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  check("done_kind", e.kind, K_DONE);
                  check("done_latency", cyc - acc_cyc, e.lat);
                  $display("done latency=%0d at cycle %0d", cyc - acc_cyc, cyc);
               end
            end
         end
      end
   end

   // Present a request and wait (bounded) until it is accepted.
   task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] mask,
                       input bit keep, output int acc);
      bit ok;
      ok = 0;
      acc = -1;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_addr  = addr[ADDR_W-1:0];
      req_data  = data;
      req_mask  = mask;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1;
            acc = cyc;
            break;
         end
      end
      if (!ok) check("accept_timeout", 32'h0, 32'h1);
      $display("request addr=%h data=%h mask=%h accepted at cycle %0d", addr, data, mask, acc);
      if (!keep) begin
         @(posedge clk);
         #1;
         req_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && req_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("idle_timeout", exp_q.size(), 32'h0);
   endtask

   initial begin
      int a0, a1;
      bit seen_we;
      reset_n = 1'b0;
      req_valid = 1'b0;
      req_addr = '0;
      req_data = 32'h0;
      req_mask = 32'h0;
      #2;
      check("rst_req_ready", {31'h0, req_ready}, 32'h1);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_mem_we", {31'h0, mem_we}, 32'h0);
      check("rst_mem_addr", {2'b0, mem_addr}, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Full mask, ack tied high: single write, done 2 cycles after accept.
      ack_delay = 0;
      push(K_WRITE, 32'h10, 32'hDEADBEEF, 0);
      push(K_DONE, 0, 0, 2);
      send(32'h10, 32'hDEADBEEF, 32'hFFFF_FFFF, 0, a0);
      wait_idle();

      // Partial mask: read, merge byte 1, write back; done 3 cycles after accept.
      rdata_val = 32'h11223344;
      push(K_READ, 32'h20, 0, 0);
      push(K_WRITE, 32'h20, 32'h11225A44, 0);
      push(K_DONE, 0, 0, 3);
      send(32'h20, 32'h77665A99, 32'h0000FF00, 0, a0);
      wait_idle();

      // Empty mask: no memory traffic, done 1 cycle after accept.
      push(K_DONE, 0, 0, 1);
      send(32'h30, 32'h12345678, 32'h0, 0, a0);
      wait_idle();

      // Partial mask with 3-cycle ack delay per access: done 9 cycles after accept.
      ack_delay = 3;
      rdata_val = 32'h01234567;
      push(K_READ, 32'h40, 0, 0);
      push(K_WRITE, 32'h40, 32'hCA23450D, 0);
      push(K_DONE, 0, 0, 9);
      send(32'h40, 32'hCAFEF00D, 32'hFF0000FF, 0, a0);
      wait_idle();

      // Reset during WRITE: mem_req drops at once, no done pulse afterwards.
      ack_delay = 4;
      rdata_val = 32'hFFFFFFFF;
      push(K_READ, 32'h50, 0, 0);
      send(32'h50, 32'h000000AB, 32'h000000FF, 0, a0);
      seen_we = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mem_req && mem_we) begin
            seen_we = 1;
            break;
         end
      end
      check("reached_write", {31'h0, seen_we}, 32'h1);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("mid_rst_done", {31'h0, done}, 32'h0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'h0, req_ready}, 32'h1);
      check("post_rst_mem_addr", {2'b0, mem_addr}, 32'h0);
      check("post_rst_mem_wdata", mem_wdata, 32'h0);
      check("post_rst_mem_we", {31'h0, mem_we}, 32'h0);
      repeat (6) @(negedge clk);

      // Back-to-back with req_valid held: second accepted right after DONE.
      ack_delay = 1;
      rdata_val = 32'hABCD0000;
      push(K_WRITE, 32'h60, 32'h11111111, 0);
      push(K_DONE, 0, 0, 3);
      push(K_READ, 32'h61, 0, 0);
      push(K_WRITE, 32'h61, 32'hABCDBEEF, 0);
      push(K_DONE, 0, 0, 5);
      send(32'h60, 32'h11111111, 32'hFFFF_FFFF, 1, a0);
      send(32'h61, 32'h0000BEEF, 32'h0000FFFF, 0, a1);
      check("b2b_accept_cycle", a1, last_done + 1);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
